// File: rtl/alu32_exec.sv
// alu32_exec: single-cycle execute stage with ALU control decode, 32-bit ALU,
// flag generation and the pc+4 / branch-target adders, all captured into one
// bank of output registers.
// Optional feature: define ALU32_EXEC_SHIFT_EN to enable the SLL/SRL datapath.
// Without it, the shift codes still decode and show on gout, but they produce
// a zero result.
module alu32_exec (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  aluop,
   input  logic [5:0]  funct,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] pc,
   input  logic [31:0] offset,
   output logic [31:0] result,
   output logic [2:0]  status,
   output logic [2:0]  gout,
   output logic [31:0] pc_plus4,
   output logic [31:0] br_target
);

   // 3-bit ALU operation codes; the numeric values are architecturally visible on gout
   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SLL = 3'b011,
      OP_SRL = 3'b100,
      OP_NOR = 3'b101,
      OP_SUB = 3'b110,
      OP_SLT = 3'b111
   } alu_op_e;

   alu_op_e     alu_op;
   logic [31:0] sum;
   logic [31:0] diff;
   logic        add_ovf;
   logic        sub_ovf;
   logic [31:0] alu_res;
   logic        alu_v;
   logic        alu_n;
   logic        alu_z;
   logic [31:0] pc_inc;
   logic [31:0] target;

   logic [31:0] result_d, result_q;
   logic [2:0]  status_d, status_q;
   logic [2:0]  gout_d, gout_q;
   logic [31:0] pc_plus4_d, pc_plus4_q;
   logic [31:0] br_target_d, br_target_q;

   // ALU control: main-control class selects the op; R-type defers to funct, unknown funct falls back to ADD
   always_comb begin
      alu_op = OP_ADD;
      case (aluop)
         2'b00: alu_op = OP_ADD;
         2'b01: alu_op = OP_SUB;
         2'b11: alu_op = OP_OR;
         default: begin
            case (funct)
               6'b100000: alu_op = OP_ADD;
               6'b100010: alu_op = OP_SUB;
               6'b100100: alu_op = OP_AND;
               6'b100101: alu_op = OP_OR;
               6'b101010: alu_op = OP_SLT;
               6'b100111: alu_op = OP_NOR;
               6'b000000: alu_op = OP_SLL;
               6'b000010: alu_op = OP_SRL;
               default:   alu_op = OP_ADD;
            endcase
         end
      endcase
   end

   // Shared add/subtract results with signed overflow: operands of like (add) or unlike (sub) sign whose result sign differs from a
   always_comb begin
      sum     = a + b;
      diff    = a - b;
      add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
   end

   // ALU result select; SLT uses the true sign of a-b (sign xor overflow) so it stays correct when the subtraction wraps
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      case (alu_op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_ADD: begin
            alu_res = sum;
            alu_v   = add_ovf;
         end
         OP_SUB: begin
            alu_res = diff;
            alu_v   = sub_ovf;
         end
         OP_NOR: alu_res = ~(a | b);
         OP_SLT: alu_res = {31'd0, diff[31] ^ sub_ovf};
`ifdef ALU32_EXEC_SHIFT_EN
         OP_SLL: alu_res = a << b[4:0];
         OP_SRL: alu_res = a >> b[4:0];
`else
         OP_SLL: alu_res = '0;
         OP_SRL: alu_res = '0;
`endif
         default: alu_res = '0;
      endcase
   end

   // Negative and zero flags are derived from whatever result was selected
   always_comb begin
      alu_n = alu_res[31];
      alu_z = (alu_res == 32'd0);
   end

   // Sequential-PC and branch-target adders, both wrapping modulo 2^32
   always_comb begin
      pc_inc = pc + 32'd4;
      target = pc_inc + offset;
   end

   // Next-state for the output bank: capture on en, otherwise hold
   always_comb begin
      result_d    = result_q;
      status_d    = status_q;
      gout_d      = gout_q;
      pc_plus4_d  = pc_plus4_q;
      br_target_d = br_target_q;
      if (en) begin
         result_d    = alu_res;
         status_d    = {alu_v, alu_n, alu_z};
         gout_d      = alu_op;
         pc_plus4_d  = pc_inc;
         br_target_d = target;
      end
   end

   // Output registers; synchronous reset clears everything and overrides en
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q    <= '0;
         status_q    <= '0;
         gout_q      <= '0;
         pc_plus4_q  <= '0;
         br_target_q <= '0;
      end else begin
         result_q    <= result_d;
         status_q    <= status_d;
         gout_q      <= gout_d;
         pc_plus4_q  <= pc_plus4_d;
         br_target_q <= br_target_d;
      end
   end

   assign result    = result_q;
   assign status    = status_q;
   assign gout      = gout_q;
   assign pc_plus4  = pc_plus4_q;
   assign br_target = br_target_q;

endmodule

// File: tb/tb_alu32_exec.sv
// tb_alu32_exec: self-checking bench for alu32_exec.
// Expected outputs are pushed to a scoreboard queue when stimulus is driven
// and popped and compared one cycle later, after the capturing edge.
// Shift expectations follow ALU32_EXEC_SHIFT_EN the same way the design does.
module tb_alu32_exec;

   typedef struct packed {
      logic [31:0] result;
      logic [2:0]  status;
      logic [2:0]  gout;
      logic [31:0] pc_plus4;
      logic [31:0] br_target;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] p;
      logic [31:0] o;
      exp_t        e;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] pc;
   logic [31:0] offset;
   logic [31:0] result;
   logic [2:0]  status;
   logic [2:0]  gout;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   alu32_exec dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .aluop     (aluop),
      .funct     (funct),
      .a         (a),
      .b         (b),
      .pc        (pc),
      .offset    (offset),
      .result    (result),
      .status    (status),
      .gout      (gout),
      .pc_plus4  (pc_plus4),
      .br_target (br_target)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model written from the operation table, independent of the RTL structure
   function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] p, input logic [31:0] o);
      logic [2:0]         code;
      logic [31:0]        r;
      logic               v;
      logic signed [32:0] wide;
      exp_t               e;
      code = 3'b010;
      case (op)
         2'b00: code = 3'b010;
         2'b01: code = 3'b110;
         2'b11: code = 3'b001;
         default: begin
            case (fn)
               6'h20:   code = 3'b010;
               6'h22:   code = 3'b110;
               6'h24:   code = 3'b000;
               6'h25:   code = 3'b001;
               6'h2A:   code = 3'b111;
               6'h27:   code = 3'b101;
               6'h00:   code = 3'b011;
               6'h02:   code = 3'b100;
               default: code = 3'b010;
            endcase
         end
      endcase
      v = 1'b0;
      r = 32'd0;
      case (code)
         3'b000: r = x & y;
         3'b001: r = x | y;
         3'b010: begin
            wide = $signed({x[31], x}) + $signed({y[31], y});
            r = wide[31:0];
            v = wide[32] ^ wide[31];
         end
         3'b110: begin
            wide = $signed({x[31], x}) - $signed({y[31], y});
            r = wide[31:0];
            v = wide[32] ^ wide[31];
         end
         3'b101: r = ~(x | y);
         3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`ifdef ALU32_EXEC_SHIFT_EN
         3'b011: r = x << y[4:0];
         3'b100: r = x >> y[4:0];
`else
         3'b011: r = 32'd0;
         3'b100: r = 32'd0;
`endif
         default: r = 32'd0;
      endcase
      e.result    = r;
      e.status    = {v, r[31], (r == 32'd0)};
      e.gout      = code;
      e.pc_plus4  = p + 32'd4;
      e.br_target = p + 32'd4 + o;
      return e;
   endfunction

   // Drives one cycle of inputs just after the falling edge
   task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [1:0] op,
                                input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] p, input logic [31:0] o);
      @(negedge clk);
      rst_n  = rst_v;
      en     = en_v;
      aluop  = op;
      funct  = fn;
      a      = x;
      b      = y;
      pc     = p;
      offset = o;
   endtask

   // Reset clears every output, with en high and with en low
   task automatic test_reset();
      exp_t got, e;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, (i == 0), 2'b10, 6'h20, $urandom, $urandom, $urandom, $urandom);
         sb.push_back('0);
         @(posedge clk);
         #1;
         got = '{result, status, gout, pc_plus4, br_target};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL reset[%0d]: got r=%h s=%b g=%b p4=%h bt=%h, expected r=%h s=%b g=%b p4=%h bt=%h",
                     i, got.result, got.status, got.gout, got.pc_plus4, got.br_target,
                     e.result, e.status, e.gout, e.pc_plus4, e.br_target);
         end
      end
   endtask

   // Hand-computed vectors: overflow, zero, SLT across overflow, shift, unknown funct
   task automatic test_vectors();
      vec_t vecs[6];
      exp_t got, e;
      vecs[0] = '{2'b10, 6'h20, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0,
                  '{32'h80000000, 3'b110, 3'b010, 32'h4, 32'h4}};
      vecs[1] = '{2'b01, 6'h3F, 32'h5, 32'h5, 32'h8, 32'h10,
                  '{32'h0, 3'b001, 3'b110, 32'hC, 32'h1C}};
      vecs[2] = '{2'b10, 6'h2A, 32'h80000000, 32'h1, 32'h100, 32'hFFFFFFFC,
                  '{32'h1, 3'b000, 3'b111, 32'h104, 32'h100}};
      vecs[3] = '{2'b10, 6'h2A, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0,
                  '{32'h0, 3'b001, 3'b111, 32'h4, 32'h4}};
      vecs[4] = '{2'b10, 6'h3F, 32'h2, 32'h3, 32'h0, 32'h0,
                  '{32'h5, 3'b000, 3'b010, 32'h4, 32'h4}};
`ifdef ALU32_EXEC_SHIFT_EN
      vecs[5] = '{2'b10, 6'h00, 32'h3, 32'h4, 32'h0, 32'h0,
                  '{32'h30, 3'b000, 3'b011, 32'h4, 32'h4}};
`else
      vecs[5] = '{2'b10, 6'h00, 32'h3, 32'h4, 32'h0, 32'h0,
                  '{32'h0, 3'b001, 3'b011, 32'h4, 32'h4}};
`endif
      foreach (vecs[i]) begin
         applyStimulus(1'b1, 1'b1, vecs[i].op, vecs[i].fn, vecs[i].x, vecs[i].y, vecs[i].p, vecs[i].o);
         sb.push_back(vecs[i].e);
         @(posedge clk);
         #1;
         got = '{result, status, gout, pc_plus4, br_target};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL vector[%0d]: got r=%h s=%b g=%b p4=%h bt=%h, expected r=%h s=%b g=%b p4=%h bt=%h",
                     i, got.result, got.status, got.gout, got.pc_plus4, got.br_target,
                     e.result, e.status, e.gout, e.pc_plus4, e.br_target);
         end
      end
   endtask

   // Every funct code and aluop class back to back, with random and corner operands
   task automatic test_back_to_back();
      logic [5:0]  fns[10];
      logic [31:0] corners[6];
      logic [31:0] x, y;
      logic [1:0]  op;
      exp_t got, e;
      fns     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02, 6'h01, 6'h3F};
      corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000001F};
      for (int i = 0; i < 60; i++) begin
         op = (i < 40) ? 2'b10 : 2'(i % 4);
         x  = (i % 3 == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         y  = (i % 2 == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         applyStimulus(1'b1, 1'b1, op, fns[i % 10], x, y, $urandom, $urandom);
         sb.push_back(model(op, fns[i % 10], x, y, pc, offset));
         @(posedge clk);
         #1;
         got = '{result, status, gout, pc_plus4, br_target};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL b2b[%0d] op=%b fn=%h a=%h b=%h: got r=%h s=%b g=%b p4=%h bt=%h, expected r=%h s=%b g=%b p4=%h bt=%h",
                     i, op, fns[i % 10], x, y, got.result, got.status, got.gout, got.pc_plus4, got.br_target,
                     e.result, e.status, e.gout, e.pc_plus4, e.br_target);
         end
      end
   endtask

   // Load an ADD, hold with en low while inputs churn, then reset with en high
   task automatic test_hold();
      exp_t got, e, held;
      held = model(2'b00, 6'h00, 32'h12345678, 32'h11111111, 32'h400, 32'h20);
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 6'h00, 32'h12345678, 32'h11111111, 32'h400, 32'h20);
            sb.push_back(held);
         end else if (i < 4) begin
            applyStimulus(1'b1, 1'b0, 2'(i), 6'(i * 7), $urandom, $urandom, $urandom, $urandom);
            sb.push_back(held);
         end else if (i == 4) begin
            applyStimulus(1'b0, 1'b1, 2'b00, 6'h00, 32'h1, 32'h1, 32'h100, 32'h4);
            sb.push_back('0);
         end else begin
            applyStimulus(1'b1, 1'b0, 2'b00, 6'h00, 32'h1, 32'h1, 32'h100, 32'h4);
            sb.push_back('0);
         end
         @(posedge clk);
         #1;
         got = '{result, status, gout, pc_plus4, br_target};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL hold[%0d]: got r=%h s=%b g=%b p4=%h bt=%h, expected r=%h s=%b g=%b p4=%h bt=%h",
                     i, got.result, got.status, got.gout, got.pc_plus4, got.br_target,
                     e.result, e.status, e.gout, e.pc_plus4, e.br_target);
         end
      end
   endtask

   // Reset arriving with a live operation discards it; first capture is the first edge with rst_n and en high
   task automatic test_reset_midop();
      exp_t got, e;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin
               applyStimulus(1'b1, 1'b1, 2'b01, 6'h00, 32'h0, 32'h1, 32'h40, 32'h8);
               sb.push_back(model(2'b01, 6'h00, 32'h0, 32'h1, 32'h40, 32'h8));
            end
            1: begin
               applyStimulus(1'b0, 1'b1, 2'b10, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'h80, 32'h8);
               sb.push_back('0);
            end
            2: begin
               applyStimulus(1'b1, 1'b0, 2'b10, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'h80, 32'h8);
               sb.push_back('0);
            end
            default: begin
               applyStimulus(1'b1, 1'b1, 2'b10, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'h80, 32'h8);
               sb.push_back(model(2'b10, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'h80, 32'h8));
            end
         endcase
         @(posedge clk);
         #1;
         got = '{result, status, gout, pc_plus4, br_target};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL reset_midop[%0d]: got r=%h s=%b g=%b p4=%h bt=%h, expected r=%h s=%b g=%b p4=%h bt=%h",
                     i, got.result, got.status, got.gout, got.pc_plus4, got.br_target,
                     e.result, e.status, e.gout, e.pc_plus4, e.br_target);
         end
      end
   endtask

   // Test sequence and summary
   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      aluop  = 2'b00;
      funct  = 6'h00;
      a      = 32'h0;
      b      = 32'h0;
      pc     = 32'h0;
      offset = 32'h0;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_hold();
      test_reset_midop();
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
